// File: rtl/ppu_pkg.sv
// ppu_pkg: shared types and constants for the PPU OAM scan / sprite path
//   ScanState      - OAM scanner state encoding
//   SPRITE_ENTRY_W - width of one packed sprite buffer entry {X, num, row}
//   SPR_*          - bit positions of the packed entry fields
//   OAM_BASE       - default OAM base address
//   SPRITE_H_*     - sprite heights for 8x8 and 8x16 modes
package ppu_pkg;

    typedef enum logic [1:0] {Idle, Scan, Done} ScanState;

    localparam int SPRITE_ENTRY_W = 18;
    localparam int SPR_X_MSB      = 17;
    localparam int SPR_X_LSB      = 10;
    localparam int SPR_NUM_MSB    = 9;
    localparam int SPR_NUM_LSB    = 4;
    localparam int SPR_ROW_MSB    = 3;
    localparam int SPR_ROW_LSB    = 0;

    localparam logic [15:0] OAM_BASE = 16'hFE00;

    localparam int SPRITE_H_SHORT = 8;
    localparam int SPRITE_H_TALL  = 16;

    function automatic logic [SPRITE_ENTRY_W-1:0] pack_sprite(
        input logic [7:0] x,
        input logic [5:0] num,
        input logic [3:0] row
    );
        pack_sprite = {x, num, row};
    endfunction

endpackage

// File: rtl/sprite_y_matcher.sv
// sprite_y_matcher: decides whether a sprite at OAM Y covers scanline LY
//   y     - raw OAM Y byte (screen line + 16)
//   ly    - current scanline
//   tall  - 1 = 8x16 sprites, 0 = 8x8
//   match - sprite intersects the scanline
//   row   - unflipped row of the sprite that lands on the scanline
module sprite_y_matcher (
    input  logic [7:0] y,
    input  logic [7:0] ly,
    input  logic       tall,
    output logic       match,
    output logic [3:0] row
);
    import ppu_pkg::*;

    logic [8:0] ly_off;
    logic [8:0] y_ext;
    logic [8:0] h;

    // 9-bit arithmetic keeps y + h from wrapping for Y near 255
    always_comb begin
        ly_off = {1'b0, ly} + 9'd16;
        y_ext  = {1'b0, y};
        h      = tall ? 9'(SPRITE_H_TALL) : 9'(SPRITE_H_SHORT);
        match  = (ly_off >= y_ext) && (ly_off < y_ext + h);
        row    = 4'(ly_off - y_ext);
    end

endmodule

// File: rtl/oam_scanner.sv
// oam_scanner: mode-2 OAM search; fills the per-line sprite buffer
//   clk_in, rst_in          - clock, asynchronous active-high reset
//   tclk_in                 - T-cycle enable; all state advances only when high
//   start_in                - begin a scan (sampled on tclk_in in Idle)
//   ly_in, tall_sprite_mode_in - scanline and 8x16 mode, latched at start
//   oam_addr_out, oam_req_out  - OAM read port request
//   oam_data_in, oam_data_valid_in - OAM read data (invalid reads as 8'hFF)
//   sprite_buffer_out       - BUF_SIZE packed {X, num, row} entries, slot k at [k*18 +: 18]
//   sprite_count_out        - number of entries written
//   busy_out                - scan in progress
//   done_out                - one T-cycle pulse after the last entry is evaluated
module oam_scanner #(
    parameter int          OAM_ENTRIES = 40,
    parameter int          BUF_SIZE    = 10,
    parameter logic [15:0] OAM_BASE    = ppu_pkg::OAM_BASE
) (
    input  logic                                       clk_in,
    input  logic                                       rst_in,
    input  logic                                       tclk_in,
    input  logic                                       start_in,
    input  logic [7:0]                                 ly_in,
    input  logic                                       tall_sprite_mode_in,
    output logic [15:0]                                oam_addr_out,
    output logic                                       oam_req_out,
    input  logic [7:0]                                 oam_data_in,
    input  logic                                       oam_data_valid_in,
    output logic [ppu_pkg::SPRITE_ENTRY_W*BUF_SIZE-1:0] sprite_buffer_out,
    output logic [3:0]                                 sprite_count_out,
    output logic                                       busy_out,
    output logic                                       done_out
);
    import ppu_pkg::*;

    localparam logic [5:0] LAST_IDX = 6'(OAM_ENTRIES - 1);
    localparam logic [3:0] BUF_LIM  = 4'(BUF_SIZE);

    ScanState                  state;
    logic                      phase;
    logic [5:0]                idx;
    logic [7:0]                ly_q;
    logic                      tall_q;
    logic [7:0]                y_q;
    logic [SPRITE_ENTRY_W-1:0] slots [BUF_SIZE];
    logic [7:0]                oam_byte;
    logic                      hit;
    logic [3:0]                row;

    assign oam_byte = oam_data_valid_in ? oam_data_in : 8'hFF;

    sprite_y_matcher u_match (
        .y     (y_q),
        .ly    (ly_q),
        .tall  (tall_q),
        .match (hit),
        .row   (row)
    );

    // byte b (0 = Y, 1 = X) of OAM entry i
    function automatic logic [15:0] entry_addr(input logic [5:0] i, input logic b);
        entry_addr = OAM_BASE + {8'h00, i, 2'b00} + {15'h0000, b};
    endfunction

    // Each entry takes two T-cycles: phase 0 captures Y, phase 1 captures X
    // and evaluates the entry against the Y latched on the previous T-cycle.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state            <= Idle;
            phase            <= 1'b0;
            idx              <= '0;
            ly_q             <= '0;
            tall_q           <= 1'b0;
            y_q              <= 8'hFF;
            sprite_count_out <= '0;
            oam_addr_out     <= '0;
            oam_req_out      <= 1'b0;
            busy_out         <= 1'b0;
            done_out         <= 1'b0;
            for (int i = 0; i < BUF_SIZE; i++) slots[i] <= '0;
        end else if (tclk_in) begin
            case (state)
                Idle: begin
                    done_out <= 1'b0;
                    if (start_in) begin
                        state            <= Scan;
                        ly_q             <= ly_in;
                        tall_q           <= tall_sprite_mode_in;
                        phase            <= 1'b0;
                        idx              <= '0;
                        sprite_count_out <= '0;
                        oam_addr_out     <= entry_addr(6'd0, 1'b0);
                        oam_req_out      <= 1'b1;
                        busy_out         <= 1'b1;
                        for (int i = 0; i < BUF_SIZE; i++) slots[i] <= '0;
                    end
                end
                Scan: begin
                    phase <= ~phase;
                    if (!phase) begin
                        y_q          <= oam_byte;
                        oam_addr_out <= entry_addr(idx, 1'b1);
                    end else begin
                        // Full buffer: later matches are dropped, keeping OAM order.
                        if (hit && sprite_count_out < BUF_LIM) begin
                            slots[sprite_count_out] <= pack_sprite(oam_byte, idx, row);
                            sprite_count_out        <= sprite_count_out + 4'd1;
                        end
                        if (idx == LAST_IDX) begin
                            state       <= Done;
                            oam_req_out <= 1'b0;
                            busy_out    <= 1'b0;
                            done_out    <= 1'b1;
                        end else begin
                            idx          <= idx + 6'd1;
                            oam_addr_out <= entry_addr(idx + 6'd1, 1'b0);
                        end
                    end
                end
                Done: begin
                    state    <= Idle;
                    done_out <= 1'b0;
                end
                default: state <= Idle;
            endcase
        end
    end

    for (genvar k = 0; k < BUF_SIZE; k++) begin : g_out
        assign sprite_buffer_out[k*SPRITE_ENTRY_W +: SPRITE_ENTRY_W] = slots[k];
    end

endmodule
